fp_mult_arbiter: RTL
====================

Name: fp_mult_arbiter

Overview:
Shares one pipelined fp_mult_top instance among N_REQ requesters. Requests are granted round-robin, issued one per cycle, and tagged through a fixed-latency tag pipeline. Each result and its 8-bit status are routed back to the requester that issued it. The block sits between the requester ports and the multiplier and also provides a drain/quiesce control for the rounding-mode reconfiguration sequence.

Parameters:
N_REQ, 4, number of requesters (2..8)
MULT_LAT, 2, cycles from the multiplier sampling a/b to z/status being valid (matches fp_mult_top)
TAG_W, $clog2(N_REQ), width of the requester index tag

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester request valid
req_a  in  32*N_REQ  operand a, requester i at [32i+31:32i]
req_b  in  32*N_REQ  operand b, same packing as req_a
req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
mult_a  out  32  registered operand a to the multiplier
mult_b  out  32  registered operand b to the multiplier
mult_valid  out  1  mult_a and mult_b hold an issued operation this cycle
mult_z  in  32  multiplier result
mult_status  in  8  multiplier status {div_by_0, unused, inexact, huge, tiny, nan, inf, zero}
rsp_valid  out  N_REQ  one-hot result strobe, one cycle long
rsp_z  out  32  result
rsp_status  out  8  status paired with rsp_z
drain  in  1  stop accepting requests and flush in-flight operations
drain_done  out  1  high while in DRAIN and nothing is in flight
busy  out  1  in-flight count is nonzero

Behaviour:
- Reset (rst=1, asynchronous) clears everything to zero: req_ready, mult_*, rsp_*, drain_done, busy, the round-robin pointer (ptr=0), the tag pipeline, the in-flight counter, and the FSM (state goes to RUN). Any operation in flight at reset is discarded and produces no rsp_valid.
- FSM states:
  - RUN: arbitration is enabled. Go to DRAIN when drain=1.
  - DRAIN: req_ready=0. drain_done = (inflight==0). Return to RUN when drain=0.
- Arbitration in RUN is combinational. Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, … mod N_REQ. req_ready is one-hot or zero. req_ready never depends on rsp or mult signals.
- On accept from index g:
  - At the next edge, mult_a/mult_b = req_a/req_b of slice g, and mult_valid=1.
  - ptr = (g+1) mod N_REQ.
  - If nothing is accepted, ptr holds and mult_valid=0. mult_a/mult_b hold their last value.
- Tag pipeline: a shift register of MULT_LAT stages of {valid, tag}. Stage 0 loads {mult_valid, tag of the issued op}. Stage MULT_LAT-1 aligns with valid mult_z.
- Response register: when the last stage is valid, at the next edge rsp_valid[tag]=1, rsp_z=mult_z and rsp_status=mult_status. Otherwise rsp_valid=0 and rsp_z/rsp_status hold.
- Latency: rsp_valid is asserted exactly MULT_LAT+2 cycles after the accept cycle. Throughput is 1 op/cycle. Responses are in issue order and cannot be stalled.
- In-flight counter width is $clog2(MULT_LAT+3). It increments on accept and decrements on rsp_valid≠0. On the same cycle it is unchanged. It never exceeds MULT_LAT+2. busy=(inflight≠0).
- drain asserted in the same cycle as req_valid: no accept, because the FSM is still RUN and drain gates req_ready combinationally. Operations accepted before drain still complete and respond.
- A held request (valid, not ready) must keep its operands stable. The arbiter does not latch unaccepted operands.

Test Plan:
- Single requester 1 sends a=0x40000000, b=0x40400000 → req_ready[1] in the same cycle. At accept+MULT_LAT+2: rsp_valid=4'b0010, rsp_z=0x40C00000, rsp_status=0x00.
- All four requesters valid continuously from reset → grants go 0,1,2,3,0,… one per cycle. rsp_valid one-hot follows the same order, 4 cycles offset. No gaps.
- Requesters 0 and 2 valid after a grant to 3 (ptr=0) → grant 0, then 2. Requester 0 re-asserts → next grant goes to 2 before 0 (fairness check).
- Issue 3 ops, assert drain on the next cycle → req_ready=0. All 3 responses arrive. drain_done rises the cycle after the last rsp_valid. Deassert drain → RUN, and grants resume from ptr.
- rst pulsed with 2 ops in flight → all outputs 0 asynchronously. No rsp_valid after release. busy=0. The first grant after reset goes to requester 0.
- Operand a=0x7F800000 (inf), b=0x00000000 from requester 3 → rsp_valid[3]. rsp_z/rsp_status equal the multiplier's nan output unmodified.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_arbiter
// Purpose  : Shares one pipelined floating-point multiplier among N_REQ
//            requesters. It grants requesters round-robin and issues at most
//            one operation per cycle. A tag pipeline routes each result and
//            its status back to the requester that issued it. A drain
//            control stops new grants and reports when no operation is in
//            flight.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 2,
  parameter int TAG_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          mult_a,
  output logic [31:0]          mult_b,
  output logic                 mult_valid,
  input  logic [31:0]          mult_z,
  input  logic [7:0]           mult_status,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_z,
  output logic [7:0]           rsp_status,
  input  logic                 drain,
  output logic                 drain_done,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MULT_LAT + 3);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  logic [TAG_W-1:0]    r_ptr;
  logic [TAG_W-1:0]    r_mult_tag;
  logic [MULT_LAT-1:0] r_tag_v;
  logic [TAG_W-1:0]    r_tag [MULT_LAT];
  logic [CNT_W-1:0]    r_inflight;

  logic [TAG_W-1:0]    w_rot_idx [N_REQ];
  logic [31:0]         w_a_arr [N_REQ];
  logic [31:0]         w_b_arr [N_REQ];
  logic                w_grant_any;
  logic [TAG_W-1:0]    w_grant_idx;
  logic [TAG_W-1:0]    w_ptr_next;
  logic                w_accept;
  logic [N_REQ-1:0]    w_rsp_onehot;

  // Search order for round-robin: slot k examines requester (ptr + k) mod N_REQ
  for (genvar k = 0; k < N_REQ; k++) begin : g_rot
    assign w_rot_idx[k] = TAG_W'((32'(r_ptr) + k) % N_REQ);
  end

  // Unpack the flat operand buses into per-requester words
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_a_arr[i] = req_a[32*i +: 32];
    assign w_b_arr[i] = req_b[32*i +: 32];
  end

  // Round-robin pick: scanning from the far end lets the slot nearest ptr win
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_rot_idx[k]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_rot_idx[k];
      end
    end
  end

  // Drain gates grants in the same cycle so that a request arriving with drain is not taken
  assign w_accept   = (r_state == ST_RUN) && !drain && w_grant_any;
  assign w_ptr_next = (w_grant_idx == TAG_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // One-hot ready for the granted requester, zero when nothing is accepted
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Issue register: capture the granted operands and tag and advance the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a     <= '0;
      mult_b     <= '0;
      mult_valid <= 1'b0;
      r_mult_tag <= '0;
      r_ptr      <= '0;
    end else begin
      mult_valid <= w_accept;
      if (w_accept) begin
        mult_a     <= w_a_arr[w_grant_idx];
        mult_b     <= w_b_arr[w_grant_idx];
        r_mult_tag <= w_grant_idx;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  // Tag pipeline tracks each issued op until its result leaves the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag_v[0] <= mult_valid;
      r_tag[0]   <= r_mult_tag;
      for (int s = 1; s < MULT_LAT; s++) begin
        r_tag_v[s] <= r_tag_v[s-1];
        r_tag[s]   <= r_tag[s-1];
      end
    end
  end

  // Decode the tag at the last stage into the owning requester's strobe
  always_comb begin
    w_rsp_onehot = '0;
    if (r_tag_v[MULT_LAT-1]) begin
      w_rsp_onehot[r_tag[MULT_LAT-1]] = 1'b1;
    end
  end

  // Response register: the data holds between results and the strobe lasts one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_z      <= '0;
      rsp_status <= '0;
    end else begin
      rsp_valid <= w_rsp_onehot;
      if (r_tag_v[MULT_LAT-1]) begin
        rsp_z      <= mult_z;
        rsp_status <= mult_status;
      end
    end
  end

  // In-flight count: an accept and a response in the same cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_accept && !(|rsp_valid)) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_accept && (|rsp_valid)) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  // Run/drain control follows the drain input level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (drain)  r_state <= ST_DRAIN;
        ST_DRAIN: if (!drain) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign drain_done = (r_state == ST_DRAIN) && (r_inflight == '0);
  assign busy       = (r_inflight != '0);

endmodule
`default_nettype wire
